cdc_pulse_scheduler: RTL and testbench
======================================

# cdc_pulse_scheduler

Source-domain scheduler that shares one toggle-based pulse synchronizer lane between several event requesters (e.g. DMA channel done/error events). It queues events per requester, grants them round-robin, and emits one single-cycle pulse at a time into the synchronizer's `signal_in`, spaced far enough apart that the destination domain resolves each pulse. A requester ID (`sync_id`) is held stable across each spacing window so the destination can sample it when the synchronized pulse arrives.

## Interface
- `N_REQ`, 4, number of requesters (2..16)
- `CNT_W`, 4, width of each per-requester pending counter; saturates at 2^CNT_W-1
- `GAP`, 8, hold cycles after each pulse; must be >= 3 and cover destination sync latency in source cycles
- `clk_in`  in  1  single clock (source domain)
- `reset`  in  1  synchronous, active-high reset
- `req_pulse`  in  N_REQ  per-requester event strobe; each high cycle = one event
- `ovf_clr`  in  N_REQ  clears matching sticky overflow bit
- `sync_pulse`  out  1  one-cycle pulse to the shared synchronizer input
- `sync_id`  out  IDW=$clog2(N_REQ)  granted requester index, stable from the FIRE cycle until the next grant
- `pend_cnt`  out  N_REQ*CNT_W  flattened pending counters, requester 0 in LSBs
- `pend_ovf`  out  N_REQ  sticky: event arrived while that counter was saturated
- `busy`  out  1  state != IDLE or any counter nonzero

## Operation
- FSM states: IDLE, FIRE, HOLD.
- IDLE: if any counter is nonzero, round-robin pick starting at `last_grant+1` (wrap at N_REQ-1), latch `sync_id`, go to FIRE; otherwise stay.
- FIRE: `sync_pulse`=1 for exactly this cycle; decrement the granted counter; load gap counter with GAP-1; go to HOLD.
- HOLD: `sync_pulse`=0; gap counter decrements; on 0 go to IDLE.
- Counter update per requester each cycle: +1 on `req_pulse`, -1 on FIRE grant. Both together → unchanged. Increment at saturation → counter held, `pend_ovf` set. A decrement in the same cycle as an increment at saturation leaves the counter saturated and does not set `pend_ovf`.
- `ovf_clr` and a new overflow in the same cycle: set wins.
- Counters never underflow; a grant is only issued to a nonzero counter.

## Timing
- Reset values: `sync_pulse`=0, `sync_id`=0, all `pend_cnt`=0, `pend_ovf`=0, `busy`=0, state IDLE, `last_grant`=N_REQ-1 (requester 0 gets priority first).
- Latency: `req_pulse` high in cycle t, scheduler idle → counter=1 in t+1 (IDLE grants), `sync_pulse` high in t+2.
- Backlog pulse period: exactly GAP+2 cycles between `sync_pulse` rising edges (FIRE 1 + HOLD GAP + IDLE 1).
- `sync_id` changes only on the clock edge entering FIRE, never during HOLD.
- All outputs are registered; no combinational path from inputs to outputs.
- `reset` mid-HOLD: next cycle is IDLE with all reset values. Pending events are discarded.

## Structure
- Shared package: state enum (IDLE/FIRE/HOLD), `clog2`-based IDW function, GAP minimum constant (3) used by an elaboration check.
- Sub-module `rr_arbiter` (N_REQ request vector + last-grant pointer → one-hot/encoded grant, combinational) instantiated once.
- Instantiates no synchronizer. The toggle-pulse synchronizer sits outside the block on `sync_pulse`.

## Test plan
- Single event: `req_pulse[2]` for 1 cycle → `sync_pulse` 2 cycles later, `sync_id`=2, `busy` falls after GAP+2 cycles.
- Simultaneous: `req_pulse`=4'b1111 for one cycle → four pulses with ids 0,1,2,3, each GAP+2=10 cycles apart.
- Fairness: req 0 pulsed every cycle for 40 cycles, req 3 pulsed once → grants alternate 0,3,0,0,… with id 3 granted second.
- Saturation: 17 `req_pulse[1]` strobes with CNT_W=4, scheduler blocked by backlog → `pend_cnt[1]`=15, `pend_ovf[1]`=1. `ovf_clr[1]` clears it.
- Same-cycle inc/dec: `req_pulse[0]` during FIRE for requester 0 with count 1 → count stays 1, a second pulse follows.
- Reset mid-HOLD with 3 pending → all counters 0, `sync_pulse` stays 0, `sync_id`=0 the next cycle.

Source files
------------

// File: rtl/cdc_pulse_scheduler_pkg.sv
// Shared types and helpers for the pulse scheduler that feeds one toggle-synchronizer lane.
package cdc_pulse_scheduler_pkg;
  typedef enum logic [1:0] {IDLE, FIRE, HOLD} state_t;

  localparam int GAP_MIN = 3;

  function automatic int idw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/cdc_pulse_scheduler_if.sv
// Requester-side and synchronizer-side signals of the pulse scheduler.
interface cdc_pulse_scheduler_if
  import cdc_pulse_scheduler_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int CNT_W = 4
);
  localparam int IDW = idw(N_REQ);

  logic [N_REQ-1:0]            req_pulse;
  logic [N_REQ-1:0]            ovf_clr;
  logic                        sync_pulse;
  logic [IDW-1:0]              sync_id;
  logic [N_REQ-1:0][CNT_W-1:0] pend_cnt;
  logic [N_REQ-1:0]            pend_ovf;
  logic                        busy;

  modport master (output req_pulse, ovf_clr,
                  input  sync_pulse, sync_id, pend_cnt, pend_ovf, busy);
  modport slave  (input  req_pulse, ovf_clr,
                  output sync_pulse, sync_id, pend_cnt, pend_ovf, busy);
endinterface

// File: rtl/cdc_pulse_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request after the last grant, wrapping.
module rr_arbiter
  import cdc_pulse_scheduler_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDW   = idw(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   last,
  output logic [N_REQ-1:0] gnt,
  output logic [IDW-1:0]   gnt_id,
  output logic             vld
);
  assign vld = |req;

  always_comb begin
    int  idx;
    logic found;
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = 0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = (int'(last) + i) % N_REQ;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = idx[IDW-1:0];
      end
    end
  end
endmodule

// File: rtl/cdc_pulse_scheduler.sv
// Queues per-requester events and serializes them as spaced single-cycle pulses with a held ID.
module cdc_pulse_scheduler
  import cdc_pulse_scheduler_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int CNT_W = 4,
  parameter int GAP   = 8
) (
  input  logic                  clk_in,
  input  logic                  reset,
  cdc_pulse_scheduler_if.slave  bus
);
  localparam int IDW = idw(N_REQ);
  localparam int GW  = idw(GAP);
  localparam logic [CNT_W-1:0] CMAX = '1;

  if (GAP < GAP_MIN) begin : g_gap_chk
    $error("GAP too small for the destination to resolve each pulse");
  end

  state_t                      state;
  logic [IDW-1:0]              last_grant, id_q;
  logic [N_REQ-1:0]            gnt_q, gnt, nz, ovf, ovf_nxt, dec;
  logic [IDW-1:0]              gnt_id;
  logic                        gnt_vld, pulse_q, busy_q, any_nxt;
  logic [GW-1:0]               gap_cnt;
  logic [N_REQ-1:0][CNT_W-1:0] cnt, cnt_nxt;

  rr_arbiter #(.N_REQ(N_REQ), .IDW(IDW)) u_arb (
    .req(nz), .last(last_grant), .gnt(gnt), .gnt_id(gnt_id), .vld(gnt_vld)
  );

  assign dec = (state == FIRE) ? gnt_q : '0;

  // Inc and dec together cancel, so a saturated counter being served never flags overflow.
  always_comb begin
    cnt_nxt = cnt;
    ovf_nxt = ovf;
    nz      = '0;
    any_nxt = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      nz[i] = (cnt[i] != '0);
      if (bus.ovf_clr[i]) ovf_nxt[i] = 1'b0;
      if (bus.req_pulse[i] && !dec[i]) begin
        if (cnt[i] == CMAX) ovf_nxt[i] = 1'b1;
        else                cnt_nxt[i] = cnt[i] + 1'b1;
      end else if (dec[i] && !bus.req_pulse[i] && nz[i]) begin
        cnt_nxt[i] = cnt[i] - 1'b1;
      end
      any_nxt = any_nxt | (cnt_nxt[i] != '0);
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= IDW'(N_REQ - 1);
      id_q       <= '0;
      gnt_q      <= '0;
      pulse_q    <= 1'b0;
      busy_q     <= 1'b0;
      gap_cnt    <= '0;
      cnt        <= '0;
      ovf        <= '0;
    end else begin
      cnt <= cnt_nxt;
      ovf <= ovf_nxt;
      case (state)
        IDLE: begin
          if (gnt_vld) begin
            state      <= FIRE;
            id_q       <= gnt_id;
            last_grant <= gnt_id;
            gnt_q      <= gnt;
            pulse_q    <= 1'b1;
            busy_q     <= 1'b1;
          end else begin
            busy_q <= any_nxt;
          end
        end
        FIRE: begin
          state   <= HOLD;
          pulse_q <= 1'b0;
          gap_cnt <= GW'(GAP - 1);
          busy_q  <= 1'b1;
        end
        HOLD: begin
          if (gap_cnt == '0) begin
            state  <= IDLE;
            busy_q <= any_nxt;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
            busy_q  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.sync_pulse = pulse_q;
  assign bus.sync_id    = id_q;
  assign bus.pend_cnt   = cnt;
  assign bus.pend_ovf   = ovf;
  assign bus.busy       = busy_q;
endmodule

// File: tb/tb_cdc_pulse_scheduler.sv
// Directed bench: table of single-event vectors plus hand-written multi-cycle sequences.
module tb_cdc_pulse_scheduler;
  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   passed = 0;
  int   cyc = 0;
  int   q_id[$];
  int   q_cyc[$];
  int   c0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cdc_pulse_scheduler_if #(.N_REQ(4), .CNT_W(4)) bus ();

  cdc_pulse_scheduler #(.N_REQ(4), .CNT_W(4), .GAP(8)) dut (
    .clk_in(clk), .reset(reset), .bus(bus)
  );

  always @(negedge clk)
    if (bus.sync_pulse === 1'b1) begin
      q_id.push_back(int'(bus.sync_id));
      q_cyc.push_back(cyc);
    end

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  clr;
    logic        pulse;
    logic [1:0]  id;
    logic [15:0] cnt;
    logic [3:0]  ovf;
    logic        busy;
  } vec_t;
  vec_t vt[11];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  task automatic reset_dut();
    bus.req_pulse = '0;
    bus.ovf_clr   = '0;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    q_id.delete();
    q_cyc.delete();
  endtask

  initial begin
    // single event on requester 2: count, FIRE, 8 HOLD cycles, IDLE
    vt[0] = '{4'b0100, 4'b0000, 1'b0, 2'd0, 16'h0100, 4'b0, 1'b1};
    vt[1] = '{4'b0000, 4'b0000, 1'b1, 2'd2, 16'h0100, 4'b0, 1'b1};
    for (int k = 2; k < 10; k++) vt[k] = '{4'b0000, 4'b0000, 1'b0, 2'd2, 16'h0000, 4'b0, 1'b1};
    vt[10] = '{4'b0000, 4'b0100, 1'b0, 2'd2, 16'h0000, 4'b0, 1'b0};

    bus.req_pulse = '0;
    bus.ovf_clr   = '0;
    reset = 1'b1;
    step();
    step();
    chk("rst_pulse", 32'(bus.sync_pulse), 32'd0);
    chk("rst_id",    32'(bus.sync_id),    32'd0);
    chk("rst_cnt",   32'(bus.pend_cnt),   32'd0);
    chk("rst_ovf",   32'(bus.pend_ovf),   32'd0);
    chk("rst_busy",  32'(bus.busy),       32'd0);
    reset = 1'b0;

    for (int k = 0; k < 11; k++) begin
      bus.req_pulse = vt[k].req;
      bus.ovf_clr   = vt[k].clr;
      step();
      chk($sformatf("vec%0d", k),
          {8'h0, bus.sync_pulse, bus.sync_id, 16'(bus.pend_cnt), bus.pend_ovf, bus.busy},
          {8'h0, vt[k].pulse, vt[k].id, vt[k].cnt, vt[k].ovf, vt[k].busy});
    end
    bus.ovf_clr = '0;

    // all four at once: ids 0..3, first two cycles after the strobe, then every 10
    reset_dut();
    c0 = cyc;
    bus.req_pulse = 4'b1111;
    step();
    bus.req_pulse = '0;
    repeat (40) step();
    chk("simul_n", 32'(q_id.size()), 32'd4);
    for (int k = 0; k < 4 && k < q_id.size(); k++) begin
      chk($sformatf("simul_id%0d", k),  32'(q_id[k]),       32'(k));
      chk($sformatf("simul_cyc%0d", k), 32'(q_cyc[k] - c0), 32'(2 + 10 * k));
    end

    // fairness: requester 0 hammered, requester 3 once
    reset_dut();
    for (int k = 0; k < 40; k++) begin
      bus.req_pulse = (k == 0) ? 4'b1001 : 4'b0001;
      step();
    end
    bus.req_pulse = '0;
    chk("fair_n", 32'(q_id.size() >= 4), 32'd1);
    if (q_id.size() >= 4) begin
      chk("fair_g0", 32'(q_id[0]), 32'd0);
      chk("fair_g1", 32'(q_id[1]), 32'd3);
      chk("fair_g2", 32'(q_id[2]), 32'd0);
      chk("fair_g3", 32'(q_id[3]), 32'd0);
    end

    // saturation: req0 once, then 17 req1 strobes; one grant to 1 lands mid-burst
    reset_dut();
    bus.req_pulse = 4'b0001;
    step();
    bus.req_pulse = 4'b0010;
    repeat (17) step();
    chk("sat_cnt", 32'(bus.pend_cnt[1]), 32'd15);
    chk("sat_ovf", 32'(bus.pend_ovf),    32'b0010);
    bus.ovf_clr = 4'b0010;
    step();
    chk("sat_setwins", 32'(bus.pend_ovf), 32'b0010);
    bus.req_pulse = '0;
    step();
    bus.ovf_clr = '0;
    chk("sat_clr",  32'(bus.pend_ovf),    32'b0000);
    chk("sat_hold", 32'(bus.pend_cnt[1]), 32'd15);

    // inc during FIRE of the same requester keeps the count
    reset_dut();
    c0 = cyc;
    bus.req_pulse = 4'b0001;
    step();
    bus.req_pulse = '0;
    step();
    chk("incdec_fire", {30'h0, bus.sync_pulse, bus.sync_id[0]}, 32'b10);
    bus.req_pulse = 4'b0001;
    step();
    bus.req_pulse = '0;
    chk("incdec_cnt", 32'(bus.pend_cnt), 32'h0001);
    repeat (12) step();
    chk("incdec_n", 32'(q_id.size()), 32'd2);
    if (q_id.size() >= 2) begin
      chk("incdec_cyc", 32'(q_cyc[1] - c0), 32'd12);
      chk("incdec_id",  32'(q_id[1]),       32'd0);
    end

    // reset in HOLD with three events pending
    reset_dut();
    bus.req_pulse = 4'b1110;
    step();
    bus.req_pulse = 4'b0001;
    step();
    bus.req_pulse = '0;
    step();
    chk("mid_pend", 32'(bus.pend_cnt), 32'h1101);
    chk("mid_id",   32'(bus.sync_id),  32'd1);
    step();
    reset = 1'b1;
    step();
    chk("mid_rst", {bus.sync_pulse, 2'(bus.sync_id), bus.busy, 16'(bus.pend_cnt)}, 32'h0);
    reset = 1'b0;
    q_id.delete();
    q_cyc.delete();
    repeat (15) step();
    chk("mid_nopulse", 32'(q_id.size()), 32'd0);
    chk("mid_idle",    32'(bus.busy),    32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
